// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-serial RAM port between instruction fetch and the
// data port. Grants one requester at a time and sequences little-endian 1/2/4-byte
// transfers. A jump flush aborts an in-flight fetch. All outputs are registered.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, FETCH, DREAD, DWRITE} state_t;

  // Registered state and its next-value counterparts.
  state_t            state, state_n;
  logic [2:0]        cnt, cnt_n;          // index of the byte currently on ram_addr
  logic [2:0]        n_bytes, n_bytes_n;  // transfer length latched at grant
  logic [31:0]       wbuf, wbuf_n;        // store data latched at grant
  logic [31:0]       rbuf, rbuf_n;        // read bytes collected so far
  logic [SW-1:0]     starve_cnt, starve_n;
  logic [ADDR_W-1:0] ram_addr_n;
  logic [7:0]        ram_dout_n;
  logic              ram_wr_n;
  logic              if_done_n, d_done_n;
  logic [31:0]       if_data_n, d_rdata_n;

  // Arbitration helpers.
  logic       if_elig, d_elig, grant_d, grant_f;
  logic [1:0] rd_idx, wr_idx;

  // Read data for byte k-1 arrives while byte k is addressed; stores look one byte ahead.
  assign rd_idx = cnt[1:0] - 2'd1;
  assign wr_idx = cnt[1:0] + 2'd1;

  // A requester whose done pulse is showing is dropping its request this cycle.
  assign if_elig = if_req && !if_done && !if_flush;
  assign d_elig  = d_req && !d_done;

  function automatic logic [2:0] size_to_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;   // size 3 is treated as a word
    endcase
  endfunction

  // Register every piece of state; synchronous reset clears it all.
  // NOTE: sequential blocks use non-blocking (<=) so every register samples the
  // values of the previous cycle regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      n_bytes    <= '0;
      wbuf       <= '0;
      rbuf       <= '0;
      starve_cnt <= '0;
      ram_addr   <= '0;
      ram_dout   <= '0;
      ram_wr     <= 1'b0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      if_data    <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      n_bytes    <= n_bytes_n;
      wbuf       <= wbuf_n;
      rbuf       <= rbuf_n;
      starve_cnt <= starve_n;
      ram_addr   <= ram_addr_n;
      ram_dout   <= ram_dout_n;
      ram_wr     <= ram_wr_n;
      if_done    <= if_done_n;
      d_done     <= d_done_n;
      if_data    <= if_data_n;
      d_rdata    <= d_rdata_n;
    end
  end

  // Next-state, arbitration and byte sequencing.
  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    n_bytes_n  = n_bytes;
    wbuf_n     = wbuf;
    rbuf_n     = rbuf;
    starve_n   = starve_cnt;
    ram_addr_n = ram_addr;
    ram_dout_n = ram_dout;
    ram_wr_n   = 1'b0;
    if_done_n  = 1'b0;
    d_done_n   = 1'b0;
    if_data_n  = if_data;
    d_rdata_n  = d_rdata;
    grant_d    = 1'b0;
    grant_f    = 1'b0;

    case (state)
      IDLE: begin
        // Data wins a tie unless fetch has already waited STARVE_LIMIT data grants.
        grant_d = d_elig && !(if_elig && starve_cnt == STARVE_MAX);
        grant_f = if_elig && !grant_d;
        if (!if_req) starve_n = '0;
        if (grant_d) begin
          cnt_n      = '0;
          n_bytes_n  = size_to_bytes(d_size);
          wbuf_n     = d_wdata;
          rbuf_n     = '0;
          ram_addr_n = d_addr;
          if (if_req && starve_cnt != STARVE_MAX) starve_n = starve_cnt + 1'b1;
          if (d_rw) begin
            state_n    = DWRITE;
            ram_wr_n   = 1'b1;
            ram_dout_n = d_wdata[7:0];
          end else begin
            state_n = DREAD;
          end
        end else if (grant_f) begin
          state_n    = FETCH;
          cnt_n      = '0;
          n_bytes_n  = 3'd4;
          rbuf_n     = '0;
          ram_addr_n = if_addr;
          starve_n   = '0;
        end
      end

      FETCH, DREAD: begin
        if (state == FETCH && if_flush) begin
          // Abandon the fetch; collected bytes are simply discarded.
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          if (cnt != 3'd0) rbuf_n[{rd_idx, 3'b000} +: 8] = ram_din;
          if (cnt == n_bytes) begin
            state_n = IDLE;
            cnt_n   = '0;
            if (state == FETCH) begin
              if_done_n = 1'b1;
              if_data_n = rbuf_n;
            end else begin
              d_done_n  = 1'b1;
              d_rdata_n = rbuf_n;
            end
          end else begin
            cnt_n      = cnt + 3'd1;
            ram_addr_n = ram_addr + ADDR_W'(1);
          end
        end
      end

      DWRITE: begin
        if (cnt + 3'd1 == n_bytes) begin
          state_n  = IDLE;
          cnt_n    = '0;
          d_done_n = 1'b1;
        end else begin
          cnt_n      = cnt + 3'd1;
          ram_addr_n = ram_addr + ADDR_W'(1);
          ram_wr_n   = 1'b1;
          ram_dout_n = wbuf[{wr_idx, 3'b000} +: 8];
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a byte-level
// memory reference model and transaction-level timing rules.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_done;
  logic [31:0] if_data;
  logic        d_req = 1'b0;
  logic        d_rw = 1'b0;
  logic [1:0]  d_size = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;

  // Expected held values of the two data outputs.
  logic [31:0] exp_if_data = '0;
  logic [31:0] exp_d_rdata = '0;

  // Byte RAM seen by the DUT, and the bench's own reference copy.
  logic [7:0] ram_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5a;
  endfunction

  // Synchronous byte RAM: read data one cycle after the address.
  always @(posedge clk) begin
    ram_din <= ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : dflt(ram_addr);
    if (ram_wr) begin
      ram_mem[ram_addr] = ram_dout;
      wr_cnt++;
    end
  end

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : dflt(a);
  endfunction

  // Little-endian n-byte load from the reference memory, upper bytes zero.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = ref_rd(a + 32'(i));
    return w;
  endfunction

  function automatic logic [31:0] ram_load(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = ram_rd(a + 32'(i));
    return w;
  endfunction

  task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] wd);
    for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram_mem[a] = b;
    ref_mem[a] = b;
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({if_done, d_done, ram_wr} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, want 000", {if_done, d_done, ram_wr});
    end
    n_tests++;
    if ({if_data, d_rdata, ram_addr, ram_dout} !== 104'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h, want 0", {if_data, d_rdata, ram_addr, ram_dout});
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if ({if_done, d_done, ram_wr} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle: got %b, want 000", {if_done, d_done, ram_wr});
    end
    exp_if_data = '0;
    exp_d_rdata = '0;
  endtask

  // Fetch of 0x13,00,00,00 from 0x100; the address input is changed after grant.
  task automatic test_fetch();
    preload(32'h100, 8'h13);
    preload(32'h101, 8'h00);
    preload(32'h102, 8'h00);
    preload(32'h103, 8'h00);
    if_req  = 1'b1;
    if_addr = 32'h100;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) if_addr = 32'hdead_beef;
      if (k <= 4) begin
        n_tests++;
        if (ram_addr !== 32'h100 + 32'(k - 1) || ram_wr !== 1'b0) begin
          n_fail++;
          $display("FAIL fetch_addr T+%0d: got %h wr=%b, want %h wr=0", k, ram_addr, ram_wr,
                   32'h100 + 32'(k - 1));
        end
      end
      n_tests++;
      if (if_done !== (k == 6)) begin
        n_fail++;
        $display("FAIL fetch_done T+%0d: got %b, want %b", k, if_done, (k == 6));
      end
      if (k == 6) begin
        if_req = 1'b0;
        exp_if_data = 32'h0000_0013;
        n_tests++;
        if (if_data !== exp_if_data) begin
          n_fail++;
          $display("FAIL fetch_data: got %h, want %h", if_data, exp_if_data);
        end
      end
    end
    tick();
  endtask

  // Simultaneous requests: data first (done T+6), fetch granted at T+6 (done T+12).
  task automatic test_priority();
    if_req  = 1'b1;
    if_addr = 32'h300;
    d_req   = 1'b1;
    d_rw    = 1'b0;
    d_size  = 2'd2;
    d_addr  = 32'h200;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_tests++;
      if (d_done !== (k == 6) || if_done !== (k == 12)) begin
        n_fail++;
        $display("FAIL prio_done T+%0d: got d=%b i=%b, want d=%b i=%b", k, d_done, if_done,
                 (k == 6), (k == 12));
      end
      if (k == 6) begin
        d_req = 1'b0;
        exp_d_rdata = ref_load(32'h200, 4);
        n_tests++;
        if (d_rdata !== exp_d_rdata) begin
          n_fail++;
          $display("FAIL prio_rdata: got %h, want %h", d_rdata, exp_d_rdata);
        end
      end
      if (k == 7) begin
        n_tests++;
        if (ram_addr !== 32'h300) begin
          n_fail++;
          $display("FAIL prio_fetch_addr: got %h, want 00000300", ram_addr);
        end
      end
      if (k == 12) begin
        if_req = 1'b0;
        exp_if_data = ref_load(32'h300, 4);
        n_tests++;
        if (if_data !== exp_if_data) begin
          n_fail++;
          $display("FAIL prio_if_data: got %h, want %h", if_data, exp_if_data);
        end
      end
    end
    tick();
  endtask

  // Both requests held; fetch is kept out of each data-done cycle by a flush, so
  // exactly LIMIT data grants happen before fetch is forced through.
  task automatic test_starve();
    int          grants;
    bit          got_if;
    logic [31:0] da;
    grants  = 0;
    got_if  = 1'b0;
    da      = 32'h480;
    if_req  = 1'b1;
    if_addr = 32'h400;
    d_req   = 1'b1;
    d_rw    = 1'b0;
    d_size  = 2'd0;
    d_addr  = da;
    for (int k = 0; k < 200 && !got_if; k++) begin
      tick();
      if_flush = 1'b0;
      if (d_done) begin
        grants++;
        exp_d_rdata = ref_load(da, 1);
        n_tests++;
        if (d_rdata !== exp_d_rdata) begin
          n_fail++;
          $display("FAIL starve_rdata #%0d: got %h, want %h", grants, d_rdata, exp_d_rdata);
        end
        da       = da + 32'd1;
        d_addr   = da;
        if_flush = 1'b1;
      end
      if (if_done) begin
        got_if = 1'b1;
        if_req = 1'b0;
        d_req  = 1'b0;
      end
    end
    if_flush = 1'b0;
    n_tests++;
    if (!got_if || grants != LIMIT) begin
      n_fail++;
      $display("FAIL starve_grants: got %0d grants fetch_seen=%0d, want %0d and 1", grants,
               got_if, LIMIT);
    end
    exp_if_data = ref_load(32'h400, 4);
    n_tests++;
    if (if_data !== exp_if_data) begin
      n_fail++;
      $display("FAIL starve_if_data: got %h, want %h", if_data, exp_if_data);
    end
    tick();
    tick();
  endtask

  // Flush at T+3 of a fetch: IDLE at T+4, a store issued at T+4 starts at T+5.
  task automatic test_flush();
    bit saw_if_done;
    saw_if_done = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h500;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (if_done) saw_if_done = 1'b1;
      if (k == 3) if_flush = 1'b1;
      if (k == 4) begin
        if_flush = 1'b0;
        if_req   = 1'b0;
        d_req    = 1'b1;
        d_rw     = 1'b1;
        d_size   = 2'd0;
        d_addr   = 32'h600;
        d_wdata  = 32'h0000_0077;
      end
      if (k == 5) begin
        n_tests++;
        if ({ram_wr, ram_addr, ram_dout} !== {1'b1, 32'h600, 8'h77}) begin
          n_fail++;
          $display("FAIL flush_next_req: got wr=%b addr=%h dout=%h, want 1 00000600 77",
                   ram_wr, ram_addr, ram_dout);
        end
      end
      if (k == 6) begin
        n_tests++;
        if (d_done !== 1'b1) begin
          n_fail++;
          $display("FAIL flush_store_done: got %b, want 1", d_done);
        end
        d_req = 1'b0;
        ref_store(32'h600, 1, 32'h77);
      end
    end
    n_tests++;
    if (saw_if_done || if_data !== exp_if_data) begin
      n_fail++;
      $display("FAIL flush_no_done: got done_seen=%0d data=%h, want 0 %h", saw_if_done,
               if_data, exp_if_data);
    end
  endtask

  // Half store 0xBEEF at 0xFFFFFFFF wraps to address 0.
  task automatic test_store_wrap();
    d_req   = 1'b1;
    d_rw    = 1'b1;
    d_size  = 2'd1;
    d_addr  = 32'hffff_ffff;
    d_wdata = 32'h1234_beef;
    tick();
    n_tests++;
    if ({ram_wr, ram_addr, ram_dout, d_done} !== {1'b1, 32'hffff_ffff, 8'hef, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_byte0: got wr=%b addr=%h dout=%h done=%b, want 1 ffffffff ef 0",
               ram_wr, ram_addr, ram_dout, d_done);
    end
    tick();
    n_tests++;
    if ({ram_wr, ram_addr, ram_dout, d_done} !== {1'b1, 32'h0, 8'hbe, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_byte1: got wr=%b addr=%h dout=%h done=%b, want 1 00000000 be 0",
               ram_wr, ram_addr, ram_dout, d_done);
    end
    tick();
    n_tests++;
    if ({d_done, ram_wr} !== 2'b10) begin
      n_fail++;
      $display("FAIL wrap_done: got done=%b wr=%b, want 1 0", d_done, ram_wr);
    end
    d_req = 1'b0;
    ref_store(32'hffff_ffff, 2, 32'h1234_beef);
    n_tests++;
    if ({ram_rd(32'hffff_ffff), ram_rd(32'h0)} !== {ref_rd(32'hffff_ffff), ref_rd(32'h0)}) begin
      n_fail++;
      $display("FAIL wrap_mem: got %h%h, want %h%h", ram_rd(32'hffff_ffff), ram_rd(32'h0),
               ref_rd(32'hffff_ffff), ref_rd(32'h0));
    end
    tick();
  endtask

  // Random single transactions: latency, data, bytes written, input latching.
  task automatic test_random();
    logic [31:0] a, wd;
    logic [1:0]  sz;
    int          kind, n, lat, w0, exp_lat;
    bit          got;
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 2));   // 0 fetch, 1 load, 2 store
      a    = 32'h1000 + $urandom_range(0, 255);
      wd   = $urandom;
      sz   = 2'($urandom);
      n    = (kind == 0) ? 4 : nbytes(sz);
      w0   = wr_cnt;
      if (kind == 0) begin
        if_req  = 1'b1;
        if_addr = a;
      end else begin
        d_req   = 1'b1;
        d_rw    = (kind == 2);
        d_size  = sz;
        d_addr  = a;
        d_wdata = wd;
      end
      got = 1'b0;
      lat = 0;
      for (int k = 1; k <= 20 && !got; k++) begin
        tick();
        if (k == 1) begin
          if_addr = $urandom;
          d_addr  = $urandom;
          d_wdata = $urandom;
          d_size  = 2'($urandom);
          d_rw    = ~d_rw;
        end
        if ((kind == 0 && if_done) || (kind != 0 && d_done)) begin
          got    = 1'b1;
          lat    = k;
          if_req = 1'b0;
          d_req  = 1'b0;
        end
      end
      if_req  = 1'b0;
      d_req   = 1'b0;
      exp_lat = (kind == 2) ? n + 1 : n + 2;
      n_tests++;
      if (!got || lat != exp_lat) begin
        n_fail++;
        $display("FAIL rand_latency #%0d kind=%0d n=%0d: got %0d done_seen=%0d, want %0d",
                 it, kind, n, lat, got, exp_lat);
      end
      if (kind == 0) begin
        exp_if_data = ref_load(a, 4);
        n_tests++;
        if (if_data !== exp_if_data) begin
          n_fail++;
          $display("FAIL rand_fetch #%0d @%h: got %h, want %h", it, a, if_data, exp_if_data);
        end
      end else if (kind == 1) begin
        exp_d_rdata = ref_load(a, n);
        n_tests++;
        if (d_rdata !== exp_d_rdata) begin
          n_fail++;
          $display("FAIL rand_load #%0d @%h n=%0d: got %h, want %h", it, a, n, d_rdata,
                   exp_d_rdata);
        end
      end else begin
        ref_store(a, n, wd);
        n_tests++;
        if (wr_cnt - w0 != n) begin
          n_fail++;
          $display("FAIL rand_wr_count #%0d: got %0d, want %0d", it, wr_cnt - w0, n);
        end
        n_tests++;
        if (ram_load(a, n) !== ref_load(a, n)) begin
          n_fail++;
          $display("FAIL rand_store_mem #%0d @%h n=%0d: got %h, want %h", it, a, n,
                   ram_load(a, n), ref_load(a, n));
        end
        n_tests++;
        if (d_rdata !== exp_d_rdata) begin
          n_fail++;
          $display("FAIL rand_rdata_hold #%0d: got %h, want %h", it, d_rdata, exp_d_rdata);
        end
      end
      tick();
    end
  endtask

  // Reset asserted during T+2 of a word store.
  task automatic test_reset_mid();
    bit bad;
    bad     = 1'b0;
    d_req   = 1'b1;
    d_rw    = 1'b1;
    d_size  = 2'd2;
    d_addr  = 32'h700;
    d_wdata = 32'hcafe_f00d;
    tick();
    tick();
    rst   = 1'b1;
    d_req = 1'b0;
    tick();
    n_tests++;
    if ({if_done, d_done, ram_wr, if_data, d_rdata, ram_addr, ram_dout} !== 107'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h, want 0",
               {if_done, d_done, ram_wr, if_data, d_rdata, ram_addr, ram_dout});
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (d_done || ram_wr || if_done) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: got activity after reset, want none");
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_starve();
    test_flush();
    test_store_wrap();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
